// File: rtl/tristate_pkg.sv
// Shared types and sizing helpers for the tristate bus arbiter and its round-robin picker.
// Pure declarations: no latency and no flow control.
package tristate_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_e;

  // Index/counter width with a floor of one bit, so N=1 or a count of 1 still yields a usable vector.
  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first set bit at or after ptr, wrapping cyclically, as a one-hot vector.
// Zero latency; vld is low when no request is set.
module rr_picker
  import tristate_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          vld
);

  // Constant bit selects keep the unrolled search free of variable indexing.
  always_comb begin
    pick = '0;
    vld  = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!vld && req[i] && (((int'(ptr) + off) % N) == i)) begin
          pick[i] = 1'b1;
          vld     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// N-way round-robin owner of a shared W-bit tristate bus, with a forced high-Z turnaround on every handover.
// Grant follows a request by one edge; bus_q lags the bus by one edge. Define TRISTATE_BUS_KEEPER_EN to hold the last driven value on bus_q while the bus floats.
module tristate_bus_arbiter
  import tristate_pkg::*;
#(
  parameter int W           = 8,
  parameter int N           = 4,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_BURST   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data_in,
  output logic [N-1:0]   grant,
  inout  wire  [W-1:0]   bus,
  output logic [W-1:0]   bus_q,
  output logic           busy
);

  localparam int PW = ptr_w(N);
  localparam int BW = ptr_w(MAX_BURST + 1);
  localparam int TW = ptr_w(TURN_CYCLES);
  localparam logic [PW-1:0] LAST_IDX  = PW'(N - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [TW-1:0] turn_q, turn_d;
  logic [W-1:0]  smp_q, bus_q_d;

  logic [N-1:0]  pick;
  logic          pick_vld;
  logic [PW-1:0] owner_idx;
  logic [PW-1:0] next_ptr;
  logic [W-1:0]  drv_dat;
  logic          owner_req;
  logic          others_req;

  rr_picker #(.N(N), .PW(PW)) u_picker (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .vld  (pick_vld)
  );

  always_comb begin
    owner_idx = '0;
    drv_dat   = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        owner_idx = PW'(i);
      end
      drv_dat = drv_dat | (data_in[i*W +: W] & {W{grant_q[i]}});
    end
  end

  assign next_ptr   = (owner_idx == LAST_IDX) ? '0 : owner_idx + PW'(1);
  assign owner_req  = |(req & grant_q);
  assign others_req = |(req & ~grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    turn_d  = turn_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = DRIVE;
          grant_d = pick;
          burst_d = BW'(1);
        end
      end
      DRIVE: begin
        if (!owner_req || (burst_q >= BURST_MAX && others_req)) begin
          state_d = TURN;
          grant_d = '0;
          turn_d  = '0;
          ptr_d   = next_ptr;
        end else if (burst_q < BURST_MAX) begin
          burst_d = burst_q + BW'(1);
        end
      end
      TURN: begin
        if (turn_q == TURN_LAST) begin
          if (pick_vld) begin
            state_d = DRIVE;
            grant_d = pick;
            burst_d = BW'(1);
          end else begin
            state_d = IDLE;
            burst_d = '0;
          end
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      turn_q  <= '0;
      smp_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      turn_q  <= turn_d;
      smp_q   <= bus_q_d;
    end
  end

`ifdef TRISTATE_BUS_KEEPER_EN
  logic [W-1:0] keep_q, keep_d;

  // The keeper only feeds bus_q; it never reaches the pins.
  always_comb begin
    keep_d  = keep_q;
    bus_q_d = keep_q;
    if (state_q == DRIVE) begin
      keep_d  = drv_dat;
      bus_q_d = bus;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keep_q <= '0;
    end else begin
      keep_q <= keep_d;
    end
  end
`else
  assign bus_q_d = bus;
`endif

  // Reset forces state_q to IDLE asynchronously, so the pins release without waiting for clk.
  assign bus   = (state_q == DRIVE) ? drv_dat : {W{1'bz}};
  assign grant = grant_q;
  assign bus_q = smp_q;
  assign busy  = (state_q != IDLE);

endmodule
